// File: rtl/video_timing_receiver.sv
// video_timing_receiver: registers a DE/HS/VS video stream into pixel coordinates,
// measures frame timing at each vsync rise and locks once it repeats.
module video_timing_receiver #(
    parameter int H_BITS      = 12,
    parameter int V_BITS      = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [23:0]       video_data,
    input  logic              video_de,
    input  logic              video_hsync,
    input  logic              video_vsync,
    output logic [23:0]       pixel_data,
    output logic              pixel_valid,
    output logic [H_BITS-1:0] pixel_x,
    output logic [V_BITS-1:0] pixel_y,
    output logic              line_start,
    output logic              frame_start,
    output logic [H_BITS-1:0] meas_htotal,
    output logic [H_BITS-1:0] meas_hactive,
    output logic [V_BITS-1:0] meas_vtotal,
    output logic [V_BITS-1:0] meas_vactive,
    output logic              locked,
    output logic              timing_error
);
    localparam logic [H_BITS-1:0] H_MAX = '1;
    localparam logic [H_BITS-1:0] H_SAT = H_MAX - 1'b1;

    typedef enum logic [1:0] {IDLE, SEARCH, CHECK, LOCKED} state_t;

    state_t            state, state_next;
    logic [3:0]        match_cnt, match_next;
    logic              primed, hs_q, vs_q, de_q;
    logic [H_BITS-1:0] hcount, de_cnt, line_total, line_active, line_len, ht_now, ha_now;
    logic [V_BITS-1:0] line_cnt, act_cnt, vt_now, va_now, y_next;
    logic              hs_rise, vs_rise, de_rise, de_fall, new_run, sat, match, lock_err;

    assign hs_rise  = primed && video_hsync && !hs_q;
    assign vs_rise  = primed && video_vsync && !vs_q;
    assign de_rise  = primed && video_de && !de_q;
    assign de_fall  = de_q && !video_de;
    assign new_run  = video_de && !de_q;
    assign sat      = !hs_rise && hcount == H_SAT;
    assign line_len = hcount + H_BITS'(hcount != H_MAX);
    // A line closing in the vsync-rise cycle belongs to the frame that is ending
    assign ht_now   = hs_rise ? line_len : line_total;
    assign ha_now   = hs_rise && de_cnt != '0 ? de_cnt : line_active;
    assign vt_now   = line_cnt + V_BITS'(hs_rise);
    assign va_now   = act_cnt + V_BITS'(de_rise);
    assign y_next   = vs_rise ? '0 : pixel_y + V_BITS'(de_fall);
    // Published meas_* always equal the stored reference once out of IDLE
    assign match    = ht_now == meas_htotal && ha_now == meas_hactive &&
                      vt_now == meas_vtotal && va_now == meas_vactive;

    always_comb begin
        state_next = state;
        match_next = match_cnt;
        lock_err   = 1'b0;
        if (sat) begin
            state_next = SEARCH;
            match_next = '0;
        end else if (vs_rise) begin
            case (state)
                IDLE:   state_next = SEARCH;
                SEARCH: begin
                    state_next = CHECK;
                    match_next = '0;
                end
                CHECK:  begin
                    match_next = match ? match_cnt + 4'd1 : '0;
                    if (match && match_cnt + 4'd1 >= 4'(LOCK_FRAMES))
                        state_next = LOCKED;
                end
                LOCKED: if (!match) begin
                    state_next = SEARCH;
                    lock_err   = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            match_cnt    <= '0;
            primed       <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            hcount       <= '0;
            de_cnt       <= '0;
            line_total   <= '0;
            line_active  <= '0;
            line_cnt     <= '0;
            act_cnt      <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            meas_htotal  <= '0;
            meas_hactive <= '0;
            meas_vtotal  <= '0;
            meas_vactive <= '0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
        end else begin
            state       <= state_next;
            match_cnt   <= match_next;
            primed      <= 1'b1;
            hs_q        <= video_hsync;
            vs_q        <= video_vsync;
            de_q        <= video_de;
            hcount      <= hs_rise ? '0 : line_len;
            de_cnt      <= hs_rise ? H_BITS'(video_de) : de_cnt + H_BITS'(video_de && de_cnt != H_MAX);
            line_total  <= ht_now;
            line_active <= ha_now;
            line_cnt    <= vs_rise ? '0 : vt_now;
            act_cnt     <= vs_rise ? '0 : va_now;
            if (vs_rise && state != IDLE) begin
                meas_htotal  <= ht_now;
                meas_hactive <= ha_now;
                meas_vtotal  <= vt_now;
                meas_vactive <= va_now;
            end
            pixel_valid <= video_de;
            if (video_de) begin
                pixel_data <= video_data;
                pixel_x    <= de_q ? pixel_x + 1'b1 : '0;
            end
            pixel_y      <= y_next;
            line_start   <= new_run;
            frame_start  <= new_run && y_next == '0;
            locked       <= state_next == LOCKED;
            timing_error <= sat || lock_err;
        end
    end
endmodule
